// File: rtl/cpu_defs.sv
// Shared CPU definitions: MDU op encodings, counter width and the MDU FSM/result types.
package cpu_defs;

  localparam int unsigned MDU_OP_W  = 3;
  localparam int unsigned MDU_CNT_W = 4;
  localparam int unsigned XLEN      = 32;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } mdu_res_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: 64-bit product or quotient/remainder as {hi, lo}.
module mdu_arith
  import cpu_defs::*;
(
  input  logic [MDU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  output mdu_res_t            o_res_c,
  output logic                o_div0_c
);

  logic signed [2*XLEN-1:0] w_sa64, w_sb64, w_sprod;
  logic        [2*XLEN-1:0] w_uprod;
  logic                     w_ovf;
  logic        [XLEN-1:0]   w_bsafe;
  logic signed [XLEN-1:0]   w_sq, w_sr;
  logic        [XLEN-1:0]   w_uq, w_ur;

  // Divisor is forced to 1 for the zero and overflow cases so the dividers never see them.
  always_comb begin
    w_sa64  = {{XLEN{i_a[XLEN-1]}}, i_a};
    w_sb64  = {{XLEN{i_b[XLEN-1]}}, i_b};
    w_sprod = w_sa64 * w_sb64;
    w_uprod = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
    w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    w_bsafe = ((i_b == '0) || w_ovf) ? XLEN'(1) : i_b;
    w_sq    = $signed(i_a) / $signed(w_bsafe);
    w_sr    = $signed(i_a) % $signed(w_bsafe);
    w_uq    = i_a / w_bsafe;
    w_ur    = i_a % w_bsafe;
    if (w_ovf) begin
      w_sq = 32'sh8000_0000;
      w_sr = '0;
    end
  end

  always_comb begin
    o_res_c  = '0;
    o_div0_c = 1'b0;
    case (i_op)
      MDU_MULT:  o_res_c = w_sprod;
      MDU_MULTU: o_res_c = w_uprod;
      MDU_DIV: begin
        o_res_c.hi = w_sr;
        o_res_c.lo = w_sq;
        o_div0_c   = (i_b == '0);
      end
      MDU_DIVU: begin
        o_res_c.hi = w_ur;
        o_res_c.lo = w_uq;
        o_div0_c   = (i_b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV with deferred HI/LO commit, single-cycle MTHI/MTLO.
module mdu
  import cpu_defs::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                busy,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo
);

  mdu_state_e             r_state, w_state_nxt;
  logic                   r_busy;
  logic [MDU_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  mdu_res_t               r_pend, w_pend_nxt, w_res;
  logic [XLEN-1:0]        r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic                   w_div0;

  mdu_arith u_arith (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_res_c  (w_res),
    .o_div0_c (w_div0)
  );

  // State register; busy is registered from the next state so it is a flop, not a decode.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= MDU_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == MDU_RUN);
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE: if (start && (op <= MDU_DIVU)) w_state_nxt = MDU_RUN;
      MDU_RUN:  if (r_cnt == '0) w_state_nxt = MDU_IDLE;
      default:  w_state_nxt = MDU_IDLE;
    endcase
  end

  // Datapath: issue in IDLE, count down and commit in RUN.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_pend_nxt = r_pend;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    if (r_state == MDU_IDLE) begin
      if (start) begin
        case (op)
          MDU_MULT, MDU_MULTU: begin
            w_cnt_nxt  = MDU_CNT_W'(MUL_CYCLES - 1);
            w_pend_nxt = w_res;
          end
          MDU_DIV, MDU_DIVU: begin
            w_cnt_nxt  = MDU_CNT_W'(DIV_CYCLES - 1);
            w_pend_nxt = w_div0 ? mdu_res_t'{hi: r_hi, lo: r_lo} : w_res;
          end
          MDU_MTHI: w_hi_nxt = a;
          MDU_MTLO: w_lo_nxt = a;
          default: ;
        endcase
      end
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - MDU_CNT_W'(1);
    end else begin
      w_hi_nxt = r_pend.hi;
      w_lo_nxt = r_pend.lo;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the execute stage, directly downstream of the general-purpose register file.
- Consumes the two register read operands (rs/rt data) and holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU as fixed-latency multi-cycle operations; executes MTHI and MTLO as single-cycle writes.
- Exports busy to the hazard unit so it can stall any later MDU instruction or MFHI/MFLO.

Parameters:
- MUL_CYCLES, default 5: busy duration in cycles for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, default 10: busy duration in cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clr_n  input  1  reset; synchronous, active-low.
- start  input  1  issue strobe, qualified by op; sampled on the rising edge.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- a  input  32  operand from the rs read port.
- b  input  32  operand from the rt read port.
- busy  output  1  high while a multiply or divide is in flight.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.

Behaviour:
- Reset: on a rising edge with clr_n=0, set hi=0, lo=0, busy=0, cycle counter=0 and the pending-result registers to 0.
  - Reset overrides everything else, including an in-flight operation, which is discarded with no commit.
- States: IDLE (busy=0) and RUN (busy=1). busy is a direct register, not decoded combinationally.
- Issue: accepted only at an edge where state is IDLE, clr_n=1 and start=1.
  - start while in RUN is ignored, including MTHI/MTLO. The upstream hazard logic must stall; no queuing.
- MULT/MULTU accepted at edge E:
  - Latch the full 64-bit product: signed for MULT, unsigned for MULTU.
  - Load counter=MUL_CYCLES-1 and enter RUN.
- DIV/DIVU accepted at edge E:
  - Latch quotient→LO and remainder→HI: signed for DIV, unsigned for DIVU.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Load counter=DIV_CYCLES-1 and enter RUN.
- RUN: each edge with counter≠0 decrements the counter.
  - The edge with counter=0 commits the pending HI/LO to hi/lo and returns to IDLE (busy=0).
  - So busy is high for exactly N cycles after E, and hi/lo change at edge E+N, where N=MUL_CYCLES or DIV_CYCLES.
- Until the commit edge, hi/lo hold their previous values. A new start is accepted from edge E+N+1 onward.
- MTHI/MTLO accepted at edge E: hi (or lo) ← a at edge E. busy stays 0, the other register is unchanged, latency is 1 edge.
- Divide by zero (b=0, DIV or DIVU): the operation runs for the full DIV_CYCLES, but hi and lo are left unchanged at commit.
- Signed overflow (DIV with a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0x00000000.
- op 6 or 7 with start=1: no state change, busy stays 0.
- Operand values a/b are used only at the issue edge; they may change freely during RUN.

Decomposition:
- Shared package (cpu_defs):
  - MDU op encodings MDU_MULT..MDU_MTLO as 3-bit localparams.
  - Counter width constant MDU_CNT_W=4.
- One natural sub-module, mdu_arith: combinational 64-bit signed/unsigned product plus quotient/remainder with the zero-divisor and overflow rules. It keeps the top level to the FSM, counter and HI/LO registers.
- No further hierarchy.

Test Plan:
- Reset mid-run: MULT a=3, b=5, then clr_n=0 on the 2nd busy cycle → busy=0, hi=0, lo=0 next cycle; no later commit.
- MULT a=0xFFFFFFFE (-2), b=3 → busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- Boundary division: MTHI a=0x11111111 and MTLO a=0x22222222 first.
  - DIVU b=0 → hi/lo still 0x11111111/0x22222222 after 10 cycles.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start while busy: MULT issued, then DIV and MTLO pulsed during busy → both ignored; only the MULT result commits; busy drops after exactly 5 cycles.
- Back-to-back: MULT commits at edge E+5; MTHI issued with start=1 at edge E+5 is ignored; MTHI at E+6 is accepted → hi=a on the next cycle.
